debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_chan.sv | 60 ++++++
 rtl/debounce_multi.sv | 46 ++++
 tb/tb_debounce_multi.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared limits and helpers for the multi-channel debouncer.
// The effective-timeout helper keeps the "0 means 1" rule in one place.
package debounce_pkg;

  localparam int MIN_CHANNELS      = 1;
  localparam int MAX_CHANNELS      = 32;
  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MAX_SYNC_STAGES   = 4;
  localparam int MAX_TIMEOUT_WIDTH = 32;

  // A zero timeout would never let the filter settle, so it behaves as one cycle.
  function automatic logic [31:0] eff_timeout(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, two-way stability filter and
// registered, mutually exclusive assert/release pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   TIMEOUT_WIDTH = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter logic POL           = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     din,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  output logic                     dout,
  output logic                     assert_pulse,
  output logic                     release_pulse
);

  localparam logic INACT = ~POL;

  logic [SYNC_STAGES-1:0]   sync_q;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic [TIMEOUT_WIDTH:0]   cnt_inc;
  logic [TIMEOUT_WIDTH:0]   t_eff;
  logic                     s;

  assign s = sync_q[SYNC_STAGES-1];

  // One extra bit on both sides of the compare so cnt+1 can never wrap.
  always_comb begin
    t_eff   = (TIMEOUT_WIDTH+1)'(eff_timeout(32'(timeout)));
    cnt_inc = {1'b0, cnt} + (TIMEOUT_WIDTH+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q        <= {SYNC_STAGES{INACT}};
      dout          <= INACT;
      cnt           <= '0;
      assert_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], din};
      assert_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt_inc >= t_eff) begin
        // Also covers a timeout lowered below the running count.
        dout <= s;
        cnt  <= '0;
        if (s == POL) assert_pulse  <= 1'b1;
        else          release_pulse <= 1'b1;
      end else begin
        cnt <= cnt_inc[TIMEOUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CHANNELS independent debounce_chan instances
// sharing one runtime timeout.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  TIMEOUT_WIDTH = 16,
  parameter int                  SYNC_STAGES   = 2,
  parameter logic [CHANNELS-1:0] POLARITY      = {CHANNELS{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CHANNELS-1:0]      data_in,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  output logic [CHANNELS-1:0]      data_out,
  output logic [CHANNELS-1:0]      assert_pulse,
  output logic [CHANNELS-1:0]      release_pulse
);

  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("debounce_multi: CHANNELS out of range");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES out of range");
  end
  if (TIMEOUT_WIDTH < 1 || TIMEOUT_WIDTH > MAX_TIMEOUT_WIDTH) begin : g_bad_width
    $error("debounce_multi: TIMEOUT_WIDTH out of range");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .POL           (POLARITY[i])
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .din           (data_in[i]),
      .timeout       (timeout),
      .dout          (data_out[i]),
      .assert_pulse  (assert_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: each stimulus pushes the expected pulse
// event (cycle, data_out, pulses) and a negedge monitor pops and compares.
module tb_debounce_multi;

  localparam int          CH  = 4;
  localparam int          TW  = 16;
  localparam int          SS  = 2;
  localparam logic [CH-1:0] POL = 4'b0011;
  localparam int          EW  = 32 + 3*CH;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] data_in;
  logic [TW-1:0] tmo;
  logic [CH-1:0] data_out;
  logic [CH-1:0] assert_pulse;
  logic [CH-1:0] release_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];
  logic [CH-1:0] last_dout;

  debounce_multi #(
    .CHANNELS      (CH),
    .TIMEOUT_WIDTH (TW),
    .SYNC_STAGES   (SS),
    .POLARITY      (POL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .timeout       (tmo),
    .data_out      (data_out),
    .assert_pulse  (assert_pulse),
    .release_pulse (release_pulse)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver helpers
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int at, input logic [CH-1:0] d,
                          input logic [CH-1:0] a, input logic [CH-1:0] r);
    exp_q.push_back({32'(at), d, a, r});
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected pulse event(s) never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_now(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (reset_n === 1'b1) begin
      if (data_out !== last_dout && (assert_pulse | release_pulse) == '0) begin
        checks++;
        failures++;
        $display("FAIL dout_no_pulse: cycle %0d data_out %b changed from %b without a pulse",
                 cyc, data_out, last_dout);
      end
      if ((assert_pulse | release_pulse) != '0) begin
        checks++;
        got = {32'(cyc), data_out, assert_pulse, release_pulse};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: cycle %0d dout %b ap %b rp %b, required no pulse",
                   cyc, data_out, assert_pulse, release_pulse);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL pulse_event: got cycle %0d dout %b ap %b rp %b, required cycle %0d dout %b ap %b rp %b",
                     got[EW-1 -: 32], got[3*CH-1 -: CH], got[2*CH-1 -: CH], got[CH-1:0],
                     e[EW-1 -: 32], e[3*CH-1 -: CH], e[2*CH-1 -: CH], e[CH-1:0]);
          end
        end
      end
    end
    last_dout <= data_out;
  end

  initial begin
    int n;
    int m;
    reset_n = 1'b0;
    data_in = 4'b1100;
    tmo     = 16'd5;

    // Reset state
    step(3);
    check_now("reset_data_out", data_out, 4'b1100);
    check_now("reset_assert", assert_pulse, 4'b0000);
    check_now("reset_release", release_pulse, 4'b0000);
    reset_n = 1'b1;
    step(6);
    check_now("idle_after_reset", data_out, 4'b1100);

    // Clean press and release on ch0, timeout=5
    n = cyc; data_in[0] = 1'b1;
    push_exp(n + 7, 4'b1101, 4'b0001, 4'b0000);
    wait_drain("press_ch0", 20);
    step(3);
    n = cyc; data_in[0] = 1'b0;
    push_exp(n + 7, 4'b1100, 4'b0000, 4'b0001);
    wait_drain("release_ch0", 20);
    step(3);

    // Bounce on ch1 with timeout=8, then settle high
    tmo = 16'd8;
    for (int p = 0; p < 10; p++) begin
      data_in[1] = 1'b1; step(2);
      data_in[1] = 1'b0; step(2);
    end
    n = cyc; data_in[1] = 1'b1;
    push_exp(n + 10, 4'b1110, 4'b0010, 4'b0000);
    wait_drain("bounce_ch1", 30);
    step(3);

    // timeout=0 acts as 1: ch2 press (active-low), ch3 one-cycle glitch
    tmo = 16'd0;
    n = cyc; data_in[2] = 1'b0;
    push_exp(n + 3, 4'b1010, 4'b0100, 4'b0000);
    wait_drain("t0_press_ch2", 10);
    step(3);
    n = cyc; data_in[3] = 1'b0;
    step(1); data_in[3] = 1'b1;
    push_exp(n + 3, 4'b0010, 4'b1000, 4'b0000);
    push_exp(n + 4, 4'b1010, 4'b0000, 4'b1000);
    wait_drain("t0_glitch_ch3", 10);
    step(3);
    tmo = 16'd1;
    n = cyc; data_in[2] = 1'b1;
    push_exp(n + 3, 4'b1110, 4'b0000, 4'b0100);
    wait_drain("t1_release_ch2", 10);
    step(3);

    // Runtime timeout drop mid-count
    tmo = 16'd100;
    n = cyc; data_in[0] = 1'b1;
    step(50);
    m = cyc; tmo = 16'd20;
    push_exp(m + 1, 4'b1111, 4'b0001, 4'b0000);
    wait_drain("timeout_drop", 10);
    step(5);

    // All channels switch together
    tmo = 16'd4;
    n = cyc; data_in = 4'b0000;
    push_exp(n + 6, 4'b0000, 4'b1100, 4'b0011);
    wait_drain("simultaneous", 20);
    step(3);

    // Reset at cnt = T-2 discards the count
    tmo = 16'd6;
    n = cyc; data_in = 4'b1111;
    step(5);
    reset_n = 1'b0;
    step(1);
    check_now("midreset_data_out", data_out, 4'b1100);
    check_now("midreset_pulses", assert_pulse | release_pulse, 4'b0000);
    step(1);
    reset_n = 1'b1;
    m = cyc;
    push_exp(m + 8, 4'b1111, 4'b0011, 4'b0000);
    wait_drain("after_midreset", 30);
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
